lcd_text_sequencer: RTL and testbench

LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

---
 rtl/lcd_text_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
// Turns a servo angle into the command/character stream for a character LCD:
// clear, home, then "ANG: HTO" with leading-zero blanking of the angle digits.
// Each output value is held for a whole slot so the downstream display
// controller can latch it at its own pace.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   update     single-cycle request to show a new angle
//   angle      angle in degrees (clamped to 180)
//   write      1 = character data, 0 = command
//   ascii_data command code or ASCII character
//   busy       high while a sequence is in progress
//   done       one-cycle pulse after the last character slot
module lcd_text_sequencer #(
  parameter int SLOT_CYCLES = 4,
  parameter int CLR_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
  input  logic [7:0] angle,
  output logic       write,
  output logic [7:0] ascii_data,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (SLOT_CYCLES > CLR_CYCLES) ? SLOT_CYCLES : CLR_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CONV, CLEAR, HOME, TEXT, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    rem, rem_nxt;        // remainder; holds the ones digit after CONV
  logic [1:0]    hund, hund_nxt;
  logic [3:0]    tens, tens_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          pend_v, pend_v_nxt;
  logic [7:0]    pend_a, pend_a_nxt;
  logic [7:0]    clamped;
  logic [7:0]    char_code;

  assign clamped = (angle > 8'd180) ? 8'd180 : angle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      hund   <= '0;
      tens   <= '0;
      cnt    <= '0;
      idx    <= '0;
      pend_v <= 1'b0;
      pend_a <= '0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      hund   <= hund_nxt;
      tens   <= tens_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      pend_v <= pend_v_nxt;
      pend_a <= pend_a_nxt;
    end
  end

  always_comb begin
    char_code = 8'h20;
    case (idx)
      3'd0: char_code = 8'h41;
      3'd1: char_code = 8'h4E;
      3'd2: char_code = 8'h47;
      3'd3: char_code = 8'h3A;
      3'd4: char_code = 8'h20;
      3'd5: char_code = (hund == 2'd0) ? 8'h20 : (8'h30 | {6'b0, hund});
      3'd6: char_code = (hund == 2'd0 && tens == 4'd0) ? 8'h20 : (8'h30 | {4'b0, tens});
      3'd7: char_code = 8'h30 | {4'b0, rem[3:0]};
      default: char_code = 8'h20;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    hund_nxt   = hund;
    tens_nxt   = tens;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    pend_v_nxt = pend_v;
    pend_a_nxt = pend_a;
    write      = 1'b0;
    ascii_data = 8'h00;
    busy       = (state != IDLE);
    done       = 1'b0;

    // Requests arriving mid-sequence are parked; the latest one wins.
    if (update && state != IDLE) begin
      pend_v_nxt = 1'b1;
      pend_a_nxt = clamped;
    end

    case (state)
      IDLE: begin
        if (update) begin
          rem_nxt   = clamped;
          hund_nxt  = '0;
          tens_nxt  = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (rem >= 8'd100) begin
          rem_nxt  = rem - 8'd100;
          hund_nxt = hund + 2'd1;
        end else if (rem >= 8'd10) begin
          rem_nxt  = rem - 8'd10;
          tens_nxt = tens + 4'd1;
        end else begin
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        ascii_data = 8'h01;
        if (cnt == CLR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = HOME;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOME: begin
        ascii_data = 8'h80;
        if (cnt == SLOT_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = TEXT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TEXT: begin
        write      = 1'b1;
        ascii_data = char_code;
        if (cnt == SLOT_LAST) begin
          cnt_nxt = '0;
          if (idx == 3'd7) state_nxt = DONE;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        // A request on this very cycle is newer than any parked one, so it
        // is used directly rather than going through the pending register.
        pend_v_nxt = 1'b0;
        hund_nxt   = '0;
        tens_nxt   = '0;
        if (update) begin
          rem_nxt   = clamped;
          state_nxt = CONV;
        end else if (pend_v) begin
          rem_nxt   = pend_a;
          state_nxt = CONV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Testbench for lcd_text_sequencer: random and directed angle updates; a
// scoreboard of expected angles is checked slot by slot against the output
// stream whenever the DUT pulses done.
module tb_lcd_text_sequencer;

  localparam int SLOT = 4;
  localparam int CLR  = 16;

  logic       clk, rst_n, update, write, busy, done;
  logic [7:0] angle, ascii_data;

  lcd_text_sequencer #(.SLOT_CYCLES(SLOT), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .update(update), .angle(angle),
    .write(write), .ascii_data(ascii_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int exp_q[$];        // angles of sequences expected to be displayed
  bit active = 0;      // a sequence is believed to be running
  bit pend_v = 0;
  int pend_a = 0;

  function automatic int clampa(input int a);
    return (a > 180) ? 180 : a;
  endfunction

  // Expected {write,data} for slot s (0 clear, 1 home, 2..9 characters).
  function automatic logic [8:0] slot_val(input int a, input int s);
    int c, h, t, o;
    logic [7:0] txt [8];
    c = clampa(a);
    h = c / 100;
    t = (c / 10) % 10;
    o = c % 10;
    txt[0] = 8'h41; txt[1] = 8'h4E; txt[2] = 8'h47; txt[3] = 8'h3A; txt[4] = 8'h20;
    txt[5] = (h == 0) ? 8'h20 : 8'(48 + h);
    txt[6] = (h == 0 && t == 0) ? 8'h20 : 8'(48 + t);
    txt[7] = 8'(48 + o);
    if (s == 0) return {1'b0, 8'h01};
    if (s == 1) return {1'b0, 8'h80};
    return {1'b1, txt[s-2]};
  endfunction

  function automatic int slot_len(input int s);
    return (s == 0) ? CLR : SLOT;
  endfunction

  // Monitor / scoreboard
  logic [8:0] samp[$];
  int  conv_cyc = 0;
  bit  chk_next = 0;
  bit  exp_busy_next = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        samp.delete();
        conv_cyc = 0;
        chk_next = 0;
      end else begin
        if (chk_next) begin
          checks++;
          if (busy !== exp_busy_next || done !== 1'b0) begin
            failures++;
            $display("FAIL after_done busy=%b done=%b exp busy=%b done=0", busy, done, exp_busy_next);
          end
          chk_next = 0;
        end
        if (done === 1'b1) begin
          checks++;
          if (write !== 1'b0 || ascii_data !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_cycle write=%b data=%h busy=%b exp 0/00/1", write, ascii_data, busy);
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done got done=1 exp no sequence");
          end else begin
            int a, pos, tot;
            a = exp_q.pop_front();
            tot = 0;
            for (int s = 0; s < 10; s++) tot += slot_len(s);
            checks++;
            if (samp.size() != tot) begin
              failures++;
              $display("FAIL seq_len angle=%0d got=%0d exp=%0d", a, samp.size(), tot);
            end
            checks++;
            if (conv_cyc < 1 || conv_cyc > 11) begin
              failures++;
              $display("FAIL conv_cycles angle=%0d got=%0d exp=1..11", a, conv_cyc);
            end
            pos = 0;
            for (int s = 0; s < 10; s++) begin
              logic [8:0] ev, av;
              bit ok;
              ev = slot_val(a, s);
              ok = 1;
              av = 9'h1FF;
              for (int k = 0; k < slot_len(s); k++) begin
                if (pos + k >= samp.size()) begin
                  ok = 0;
                end else if (samp[pos+k] !== ev) begin
                  if (ok) av = samp[pos+k];
                  ok = 0;
                end
              end
              checks++;
              if (!ok) begin
                failures++;
                $display("FAIL slot%0d angle=%0d got=%h exp=%h", s, a, av, ev);
              end
              pos += slot_len(s);
            end
          end
          if (pend_v) begin
            exp_q.push_back(pend_a);
            pend_v = 0;
            exp_busy_next = 1;
          end else begin
            active = 0;
            exp_busy_next = 0;
          end
          chk_next = 1;
          samp.delete();
          conv_cyc = 0;
        end else if (busy === 1'b1) begin
          if (write === 1'b0 && ascii_data === 8'h00) conv_cyc++;
          else samp.push_back({write, ascii_data});
        end else begin
          checks++;
          if (write !== 1'b0 || ascii_data !== 8'h00 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs write=%b data=%h done=%b exp 0/00/0", write, ascii_data, done);
          end
        end
      end
    end
  end

  // Stimulus; called at posedge+1 phase.
  task automatic issue(input int a);
    bit was_active;
    was_active = active;
    if (!active) begin
      exp_q.push_back(a);
      active = 1;
    end else begin
      pend_v = 1;
      pend_a = a;
    end
    update = 1'b1;
    angle  = 8'(a);
    @(posedge clk); #1;
    update = 1'b0;
    if (!was_active) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_rise got=%b exp=1", busy);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (write !== 1'b0 || ascii_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s write=%b data=%h busy=%b done=%b exp all zero", tag, write, ascii_data, busy, done);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    active = 0;
    pend_v = 0;
    #1;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active || exp_q.size() != 0) && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 600) begin
      checks++;
      failures++;
      $display("FAIL timeout_idle got=busy exp=idle within 600 cycles");
      do_reset();
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    update = 1'b0;
    angle  = 8'h00;
    #3;
    check_reset_outputs("reset_state");
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    // Directed: nominal, clamp and blanking cases
    issue(90);  wait_idle();
    issue(180); wait_idle();
    issue(200); wait_idle();
    issue(0);   wait_idle();
    issue(7);   wait_idle();

    // Two requests while busy: the later one follows without a gap
    issue(10);
    wait_cycles(20);
    issue(45);
    wait_cycles(10);
    issue(120);
    wait_idle();

    // Request landing exactly on the done cycle
    issue(64);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wait_done got=%b exp=1", done);
    end
    issue(33);
    wait_idle();

    // Reset in the middle of the text phase
    issue(155);
    n = 0;
    while (write !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (write !== 1'b1) begin
      failures++;
      $display("FAIL wait_text got=%b exp=1", write);
    end
    do_reset();
    wait_cycles(12);
    check_reset_outputs("idle_after_reset");
    issue(99); wait_idle();

    // Random traffic: back-to-back, overlapping and isolated requests
    for (int i = 0; i < 25; i++) begin
      int a, mode;
      a = $urandom_range(0, 255);
      mode = $urandom_range(0, 2);
      if (mode == 0) wait_idle();
      else wait_cycles($urandom_range(0, 70));
      issue(a);
    end
    wait_idle();
    wait_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
